// File: rtl/vote_tally_session.sv
// Timed voting session over N_VOTERS single-bit voters.
// Each voter's first assertion during a session is latched as a sticky vote and counted.
// On close (or timeout) the count is judged under the selected rule and the result is held
// for readout until the next session opens or reset.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   votes_i         voter levels, bit i = voter i
//   open_i          pulse: start a new session (from IDLE or DONE)
//   close_i         pulse: end the open session
//   mode_i          00 any, 01 majority, 10 unanimous, 11 threshold (latched at close)
//   thresh_i        threshold for mode 11 (latched at close)
//   busy_o          session open or being tallied
//   voted_o         sticky per-voter vote mask
//   count_o         number of voters that have voted
//   result_valid_o  result available
//   result_o        pass (1) / fail (0), meaningful with result_valid_o
//   timed_out_o     session ended by timeout, valid with result_valid_o
module vote_tally_session #(
  parameter int unsigned N_VOTERS = 8,
  parameter int unsigned TIMEOUT  = 0,
  parameter int unsigned TO_W     = 16,
  localparam int unsigned CNT_W   = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_VOTERS-1:0] votes_i,
  input  logic                open_i,
  input  logic                close_i,
  input  logic [1:0]          mode_i,
  input  logic [CNT_W-1:0]    thresh_i,
  output logic                busy_o,
  output logic [N_VOTERS-1:0] voted_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                result_valid_o,
  output logic                result_o,
  output logic                timed_out_o
);

  typedef enum logic [1:0] {StIdle, StOpen, StTally, StDone} state_e;

  // Only compared against when TIMEOUT != 0, so the wrap for TIMEOUT == 0 is harmless.
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [N_VOTERS-1:0]  voted_q, voted_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [CNT_W-1:0]     thresh_q, thresh_d;
  logic                 to_flag_q, to_flag_d;
  logic                 result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 timed_out_q, timed_out_d;
  logic                 busy_q, busy_d;

  logic [N_VOTERS-1:0]  new_votes;
  logic [CNT_W-1:0]     new_cnt;
  logic [CNT_W:0]       twice_cnt;
  logic                 to_hit;
  logic                 pass;

  always_comb begin
    new_votes = votes_i & ~voted_q;
    new_cnt   = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      new_cnt = new_cnt + CNT_W'(new_votes[i]);
    end

    to_hit    = (TIMEOUT != 0) && (to_cnt_q == ToLast);
    twice_cnt = {count_q, 1'b0};

    case (mode_q)
      2'b00:   pass = (count_q != '0);
      2'b01:   pass = (twice_cnt > (CNT_W + 1)'(N_VOTERS));
      2'b10:   pass = (count_q == CNT_W'(N_VOTERS));
      default: pass = (count_q >= thresh_q);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    voted_d   = voted_q;
    count_d   = count_q;
    to_cnt_d  = to_cnt_q;
    mode_d    = mode_q;
    thresh_d  = thresh_q;
    to_flag_d = to_flag_q;
    result_d  = result_q;

    case (state_q)
      StIdle, StDone: begin
        // Votes present in the open cycle are deliberately dropped.
        if (open_i) begin
          state_d   = StOpen;
          voted_d   = '0;
          count_d   = '0;
          to_cnt_d  = '0;
          to_flag_d = 1'b0;
          result_d  = 1'b0;
        end
      end
      StOpen: begin
        voted_d  = voted_q | new_votes;
        count_d  = count_q + new_cnt;
        to_cnt_d = to_cnt_q + 1'b1;
        // An explicit close beats a coincident timeout.
        if (close_i || to_hit) begin
          state_d   = StTally;
          mode_d    = mode_i;
          thresh_d  = thresh_i;
          to_flag_d = !close_i;
        end
      end
      StTally: begin
        result_d = pass;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Status lags the result register by one cycle so result_o is settled when valid rises;
    // busy covers that extra cycle so there is no gap between busy and valid.
    busy_d         = (state_d == StOpen) || (state_d == StTally) || (state_q == StTally);
    result_valid_d = (state_q == StDone) && !open_i;
    timed_out_d    = result_valid_d && to_flag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      voted_q        <= '0;
      count_q        <= '0;
      to_cnt_q       <= '0;
      mode_q         <= 2'b00;
      thresh_q       <= '0;
      to_flag_q      <= 1'b0;
      result_q       <= 1'b0;
      result_valid_q <= 1'b0;
      timed_out_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      voted_q        <= voted_d;
      count_q        <= count_d;
      to_cnt_q       <= to_cnt_d;
      mode_q         <= mode_d;
      thresh_q       <= thresh_d;
      to_flag_q      <= to_flag_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timed_out_q    <= timed_out_d;
      busy_q         <= busy_d;
    end
  end

  assign busy_o         = busy_q;
  assign voted_o        = voted_q;
  assign count_o        = count_q;
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign timed_out_o    = timed_out_q;

endmodule

// File: tb/tb_vote_tally_session.sv
// Directed bench for vote_tally_session: instance a has no timeout, instance b TIMEOUT=5.
module tb_vote_tally_session;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] votes;
  logic       open_a, close_a, open_b, close_b;
  logic [1:0] mode;
  logic [3:0] thresh;

  logic       a_busy, a_rv, a_res, a_to;
  logic [7:0] a_voted;
  logic [3:0] a_count;
  logic       b_busy, b_rv, b_res, b_to;
  logic [7:0] b_voted;
  logic [3:0] b_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vote_tally_session #(.N_VOTERS(8), .TIMEOUT(0), .TO_W(16)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .votes_i       (votes),
    .open_i        (open_a),
    .close_i       (close_a),
    .mode_i        (mode),
    .thresh_i      (thresh),
    .busy_o        (a_busy),
    .voted_o       (a_voted),
    .count_o       (a_count),
    .result_valid_o(a_rv),
    .result_o      (a_res),
    .timed_out_o   (a_to)
  );

  vote_tally_session #(.N_VOTERS(8), .TIMEOUT(5), .TO_W(16)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .votes_i       (votes),
    .open_i        (open_b),
    .close_i       (close_b),
    .mode_i        (mode),
    .thresh_i      (thresh),
    .busy_o        (b_busy),
    .voted_o       (b_voted),
    .count_o       (b_count),
    .result_valid_o(b_rv),
    .result_o      (b_res),
    .timed_out_o   (b_to)
  );

  // Inputs set before a step are sampled at that edge; outputs are read 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_a_session(input logic [7:0] v);
    open_a = 1'b1;
    votes  = v;
    step();
    open_a = 1'b0;
    votes  = 8'h00;
  endtask

  // Close with the given votes in the close cycle, then wait until the result is valid.
  task automatic close_a_session(input logic [1:0] m, input logic [3:0] th, input logic [7:0] v);
    close_a = 1'b1;
    mode    = m;
    thresh  = th;
    votes   = v;
    step();
    close_a = 1'b0;
    votes   = 8'h00;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0h want 0", a_busy); end
    n_checks++; if (a_voted !== 8'h00) begin n_errors++; $display("FAIL reset_voted got %0h want 0", a_voted); end
    n_checks++; if (a_count !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", a_count); end
    n_checks++; if (a_rv !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0h want 0", a_rv); end
    n_checks++; if (a_res !== 1'b0) begin n_errors++; $display("FAIL reset_result got %0h want 0", a_res); end
    n_checks++; if (a_to !== 1'b0) begin n_errors++; $display("FAIL reset_timed_out got %0h want 0", a_to); end
    n_checks++; if (b_busy !== 1'b0) begin n_errors++; $display("FAIL reset_b_busy got %0h want 0", b_busy); end
  endtask

  task automatic test_basic_majority();
    open_a_session(8'hAA);  // open-cycle votes must be dropped
    n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL maj_busy_open got %0h want 1", a_busy); end
    n_checks++; if (a_count !== 4'd0) begin n_errors++; $display("FAIL maj_open_cycle_count got %0d want 0", a_count); end
    votes = 8'h07;
    step();
    votes = 8'h18;
    step();
    close_a = 1'b1;
    mode    = 2'b01;
    votes   = 8'h00;
    step();  // edge t
    close_a = 1'b0;
    n_checks++; if (a_count !== 4'd5) begin n_errors++; $display("FAIL maj_count got %0d want 5", a_count); end
    n_checks++; if (a_voted !== 8'h1F) begin n_errors++; $display("FAIL maj_voted got %0h want 1f", a_voted); end
    n_checks++; if (a_rv !== 1'b0) begin n_errors++; $display("FAIL maj_valid_t got %0h want 0", a_rv); end
    step();  // edge t+1
    n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL maj_busy_t1 got %0h want 1", a_busy); end
    n_checks++; if (a_rv !== 1'b0) begin n_errors++; $display("FAIL maj_valid_t1 got %0h want 0", a_rv); end
    step();  // edge t+2
    n_checks++; if (a_rv !== 1'b1) begin n_errors++; $display("FAIL maj_valid_t2 got %0h want 1", a_rv); end
    n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL maj_busy_t2 got %0h want 0", a_busy); end
    n_checks++; if (a_res !== 1'b1) begin n_errors++; $display("FAIL maj_result got %0h want 1", a_res); end
    n_checks++; if (a_to !== 1'b0) begin n_errors++; $display("FAIL maj_timed_out got %0h want 0", a_to); end
    step();
    n_checks++; if (a_rv !== 1'b1) begin n_errors++; $display("FAIL maj_valid_hold got %0h want 1", a_rv); end
  endtask

  task automatic test_sticky_tie();
    open_a_session(8'h00);
    n_checks++; if (a_rv !== 1'b0) begin n_errors++; $display("FAIL tie_valid_cleared got %0h want 0", a_rv); end
    n_checks++; if (a_voted !== 8'h00) begin n_errors++; $display("FAIL tie_voted_cleared got %0h want 0", a_voted); end
    votes = 8'h0F;
    repeat (10) step();
    votes = 8'h00;
    step();
    n_checks++; if (a_voted !== 8'h0F) begin n_errors++; $display("FAIL tie_no_retract got %0h want 0f", a_voted); end
    close_a_session(2'b01, 4'd0, 8'h00);
    n_checks++; if (a_count !== 4'd4) begin n_errors++; $display("FAIL tie_count got %0d want 4", a_count); end
    n_checks++; if (a_res !== 1'b0) begin n_errors++; $display("FAIL tie_result got %0h want 0", a_res); end
    open_a_session(8'h00);
    votes = 8'h0F;
    repeat (10) step();
    close_a_session(2'b11, 4'd4, 8'h00);
    n_checks++; if (a_count !== 4'd4) begin n_errors++; $display("FAIL thresh4_count got %0d want 4", a_count); end
    n_checks++; if (a_res !== 1'b1) begin n_errors++; $display("FAIL thresh4_result got %0h want 1", a_res); end
  endtask

  task automatic test_same_cycle();
    open_a_session(8'hFF);
    step();
    close_a_session(2'b00, 4'd0, 8'h80);
    n_checks++; if (a_voted !== 8'h80) begin n_errors++; $display("FAIL close_cycle_voted got %0h want 80", a_voted); end
    n_checks++; if (a_count !== 4'd1) begin n_errors++; $display("FAIL close_cycle_count got %0d want 1", a_count); end
    n_checks++; if (a_res !== 1'b1) begin n_errors++; $display("FAIL close_cycle_any got %0h want 1", a_res); end
    // open and close together from DONE: open wins, close ignored
    open_a  = 1'b1;
    close_a = 1'b1;
    votes   = 8'h01;
    step();
    open_a  = 1'b0;
    close_a = 1'b0;
    votes   = 8'h00;
    n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL openclose_busy got %0h want 1", a_busy); end
    n_checks++; if (a_count !== 4'd0) begin n_errors++; $display("FAIL openclose_count got %0d want 0", a_count); end
    n_checks++; if (a_voted !== 8'h00) begin n_errors++; $display("FAIL openclose_voted got %0h want 0", a_voted); end
    n_checks++; if (a_rv !== 1'b0) begin n_errors++; $display("FAIL openclose_valid got %0h want 0", a_rv); end
    step();
    step();
    step();
    n_checks++; if (a_busy !== 1'b1 || a_rv !== 1'b0) begin
      n_errors++; $display("FAIL openclose_still_open got busy=%0h valid=%0h want busy=1 valid=0", a_busy, a_rv);
    end
    close_a_session(2'b00, 4'd0, 8'h00);
    n_checks++; if (a_res !== 1'b0) begin n_errors++; $display("FAIL any_zero got %0h want 0", a_res); end
  endtask

  task automatic test_timeout();
    mode   = 2'b00;
    open_b = 1'b1;
    step();
    open_b = 1'b0;
    votes  = 8'h01;
    step();  // OPEN cycle 1
    votes  = 8'h00;
    step();
    step();
    step();  // OPEN cycle 4
    n_checks++; if (b_busy !== 1'b1) begin n_errors++; $display("FAIL to_busy_c4 got %0h want 1", b_busy); end
    step();  // OPEN cycle 5: timeout fires
    step();
    n_checks++; if (b_rv !== 1'b0) begin n_errors++; $display("FAIL to_valid_early got %0h want 0", b_rv); end
    step();
    n_checks++; if (b_rv !== 1'b1) begin n_errors++; $display("FAIL to_valid got %0h want 1", b_rv); end
    n_checks++; if (b_to !== 1'b1) begin n_errors++; $display("FAIL to_flag got %0h want 1", b_to); end
    n_checks++; if (b_res !== 1'b1) begin n_errors++; $display("FAIL to_result got %0h want 1", b_res); end
    n_checks++; if (b_count !== 4'd1) begin n_errors++; $display("FAIL to_count got %0d want 1", b_count); end
    // close coincides with the timeout cycle
    open_b = 1'b1;
    step();
    open_b = 1'b0;
    n_checks++; if (b_to !== 1'b0) begin n_errors++; $display("FAIL to_flag_cleared got %0h want 0", b_to); end
    repeat (4) step();
    close_b = 1'b1;
    votes   = 8'h02;
    step();
    close_b = 1'b0;
    votes   = 8'h00;
    step();
    step();
    n_checks++; if (b_rv !== 1'b1) begin n_errors++; $display("FAIL to_close_valid got %0h want 1", b_rv); end
    n_checks++; if (b_to !== 1'b0) begin n_errors++; $display("FAIL to_close_flag got %0h want 0", b_to); end
    n_checks++; if (b_voted !== 8'h02) begin n_errors++; $display("FAIL to_close_voted got %0h want 02", b_voted); end
  endtask

  task automatic test_unanimous_any();
    open_a_session(8'h00);
    close_a_session(2'b10, 4'd0, 8'hFF);
    n_checks++; if (a_count !== 4'd8) begin n_errors++; $display("FAIL unan_ff_count got %0d want 8", a_count); end
    n_checks++; if (a_res !== 1'b1) begin n_errors++; $display("FAIL unan_ff got %0h want 1", a_res); end
    open_a_session(8'h00);
    close_a_session(2'b10, 4'd0, 8'h7F);
    n_checks++; if (a_count !== 4'd7) begin n_errors++; $display("FAIL unan_7f_count got %0d want 7", a_count); end
    n_checks++; if (a_res !== 1'b0) begin n_errors++; $display("FAIL unan_7f got %0h want 0", a_res); end
    open_a_session(8'h00);
    close_a_session(2'b11, 4'd0, 8'h00);
    n_checks++; if (a_res !== 1'b1) begin n_errors++; $display("FAIL thresh0 got %0h want 1", a_res); end
    open_a_session(8'h00);
    close_a_session(2'b11, 4'd5, 8'h0F);
    n_checks++; if (a_res !== 1'b0) begin n_errors++; $display("FAIL thresh5_count4 got %0h want 0", a_res); end
  endtask

  task automatic test_reset_mid();
    open_a_session(8'h00);
    votes = 8'h33;
    step();
    n_checks++; if (a_count !== 4'd4) begin n_errors++; $display("FAIL mid_count_pre got %0d want 4", a_count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy got %0h want 0", a_busy); end
    n_checks++; if (a_voted !== 8'h00) begin n_errors++; $display("FAIL mid_voted got %0h want 0", a_voted); end
    n_checks++; if (a_count !== 4'd0) begin n_errors++; $display("FAIL mid_count got %0d want 0", a_count); end
    n_checks++; if (a_rv !== 1'b0) begin n_errors++; $display("FAIL mid_valid got %0h want 0", a_rv); end
    step();
    step();
    n_checks++; if (a_count !== 4'd0) begin n_errors++; $display("FAIL idle_ignores got %0d want 0", a_count); end
    open_a  = 1'b1;
    step();
    open_a  = 1'b0;
    step();
    n_checks++; if (a_count !== 4'd4) begin n_errors++; $display("FAIL reopen_count got %0d want 4", a_count); end
    votes = 8'h00;
  endtask

  initial begin
    rst     = 1'b0;
    votes   = 8'h00;
    open_a  = 1'b0;
    close_a = 1'b0;
    open_b  = 1'b0;
    close_b = 1'b0;
    mode    = 2'b00;
    thresh  = 4'd0;
    test_reset();
    test_basic_majority();
    test_sticky_tie();
    test_same_cycle();
    test_timeout();
    test_unanimous_any();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vote_tally_session.md
Name: vote_tally_session

Overview:
- Parametrised successor to the combinational any-voter OR block.
- Runs a timed voting session over N_VOTERS single-bit voter inputs. Each voter's first assertion is latched as a sticky vote, and the yes votes are counted.
- On close, it computes a pass/fail result under a selectable rule: any, majority, unanimous or threshold.
- Sits behind the top-level pin wrapper; votes come from ui_in and the result, count and status drive uo_out.

Parameters:
- N_VOTERS, 8, number of voter inputs; legal range 1..32.
- TIMEOUT, 0, session auto-close after this many OPEN cycles; 0 disables auto-close.
- TO_W, 16, width of the timeout counter; TIMEOUT must be < 2^TO_W.
- Derived localparam CNT_W = $clog2(N_VOTERS+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- votes_i  in  N_VOTERS  voter inputs, level, bit i = voter i.
- open_i  in  1  pulse: start a new session.
- close_i  in  1  pulse: end the session.
- mode_i  in  2  00 any, 01 majority, 10 unanimous, 11 threshold.
- thresh_i  in  CNT_W  threshold for mode 11.
- busy_o  out  1  high in OPEN or TALLY.
- voted_o  out  N_VOTERS  sticky per-voter vote mask.
- count_o  out  CNT_W  popcount of voted_o.
- result_valid_o  out  1  high in DONE.
- result_o  out  1  pass (1) / fail (0); meaningful only when result_valid_o=1.
- timed_out_o  out  1  high in DONE if the session ended by timeout.

Behaviour:
- Reset (rst sampled high at a rising edge): state=IDLE; voted_o=0, count_o=0, result_valid_o=0, result_o=0, timed_out_o=0, busy_o=0, timeout counter=0. Reset overrides everything, including mid-session; partial votes are discarded.
- States: IDLE, OPEN, TALLY, DONE.
- IDLE / DONE, open_i=1:
  - Next state OPEN; clear voted_o, count_o, timeout counter, result_valid_o, result_o, timed_out_o.
  - close_i in the same cycle is ignored.
  - votes_i in the cycle open_i is sampled are not counted.
- OPEN:
  - Each cycle, new = votes_i & ~voted_o. voted_o |= new; count_o += popcount(new). Multiple voters in one cycle are all counted.
  - Votes cannot be retracted: a deasserted input leaves its bit set. Holding a voter high counts it once.
  - open_i is ignored.
  - close_i=1 -> next state TALLY. Votes sampled in the close cycle ARE counted. mode_i and thresh_i are latched in this cycle.
  - If TIMEOUT>0: the counter increments each OPEN cycle. When the counter==TIMEOUT-1 and close_i=0, go to TALLY with timed_out flag set, latching mode_i/thresh_i and counting that cycle's votes. If close_i coincides with timeout, close_i wins and timed_out=0.
- TALLY (exactly one cycle):
  - votes_i ignored; result computed from the final count_o and latched mode into the result register.
  - Next state DONE.
- Result rules (c = count_o):
  - any: c != 0.
  - majority: 2*c > N_VOTERS (strict; a tie fails).
  - unanimous: c == N_VOTERS.
  - threshold: c >= thresh_i_latched; thresh=0 always passes.
- Latency: close_i sampled at edge t -> busy_o high through t+1 -> result_valid_o high from edge t+2. result_valid_o stays high until open_i or rst.
- DONE: votes_i ignored; voted_o and count_o are held for readout.
- busy_o is a registered decode of state; all outputs are registered.
- Arithmetic: count_o cannot overflow, since CNT_W holds N_VOTERS. The comparison 2*c uses CNT_W+1 bits.

Test Plan:
- Basic majority, N=8, TIMEOUT=0: rst; open; votes 0x07 for one cycle, then 0x18; close with mode=01 -> count_o=5, voted_o=0x1F, result_valid_o two edges after close, result_o=1.
- Sticky/duplicate and tie: open; hold votes 0x0F for 10 cycles, then drop to 0; close with mode=01 -> count_o=4 (not 40), result_o=0 (tie fails). Repeat the session with mode=11, thresh=4 -> result_o=1.
- Same-cycle events:
  - votes 0x80 in the close_i cycle -> counted.
  - votes in the open_i cycle -> not counted.
  - open_i and close_i together from DONE -> OPEN with everything cleared, close ignored.
- Timeout, TIMEOUT=5: open; vote 0x01; no close -> TALLY after 5 OPEN cycles, timed_out_o=1; mode=00 -> result_o=1. Second run with close_i on the timeout cycle -> timed_out_o=0.
- Unanimous/any edges:
  - 0xFF -> unanimous passes.
  - 0x7F -> unanimous fails.
  - 0x00 -> any fails; threshold with thresh=0 passes.
- Reset mid-session: open; votes 0x33; rst one cycle -> state IDLE, voted_o=0, count_o=0, busy_o=0, result_valid_o=0; votes ignored until the next open.
